multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the 9-bit processor. It replaces purely combinational decode with a state machine that fetches, decodes, executes, accesses memory and writes back. It generalises instruction/field widths, adds a memory-ready handshake with timeout, branch resolution, and halt/resume. It sits between instruction memory/IR and the datapath (PC, register file, ALU, data memory).

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/mem_timeout_cnt.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the multi-cycle control sequencer.
//   state_e      : sequencer states
//   instr_type_e : instruction type field encoding
//   HALT_FUNC_BIT: the halt function code is this bit replicated over the
//                  whole function field (all-ones)
//   LS_BIT_FROM_MSB: position of the load/store select bit, counted down
//                  from the function-field MSB (0 = the MSB itself)
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    R = 2'd0,
    M = 2'd1,
    B = 2'd2,
    S = 2'd3
  } instr_type_e;

  localparam logic HALT_FUNC_BIT   = 1'b1;
  localparam int   LS_BIT_FROM_MSB = 0;

endpackage

// File: rtl/mem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt
// Counts cycles spent in the MEM state and flags the cycle on which the
// data-memory wait has lasted TIMEOUT cycles.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   clr     : restart the count (asserted the cycle before MEM is entered)
//   en      : sequencer is in MEM this cycle
//   expired : this is MEM cycle number TIMEOUT (combinational)
// ---------------------------------------------------------------------------
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int           W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  // cnt_q holds (MEM cycle number - 1) while en is high.
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// with branch resolution, data-memory handshake with timeout, and halt/resume.
//
// Optional feature macro: CTRL_PERF_EN
//   defined   : cycle_cnt / retired_cnt are live performance counters
//   undefined : both counters are tied to zero and no counter flops exist
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   instr         : instruction word (type field at the top, func below it)
//   instr_valid   : instr valid (only looked at in FETCH)
//   mem_ready     : data memory done (only looked at in MEM)
//   branch_taken  : ALU branch condition (drives jump in EXEC of a branch)
//   resume        : leave HALT (only looked at in HALT)
//   ir_load       : latch instr into IR
//   pc_en, jump   : PC update / take branch target
//   mem_read, mem_write, reg_write : datapath strobes
//   alu_op        : latched function field
//   halted        : in HALT
//   mem_err       : sticky data-memory timeout flag
//   cycle_cnt     : cycles since reset, frozen in HALT
//   retired_cnt   : retired instructions
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 9,
  parameter int TYPE_W      = 2,
  parameter int FUNC_W      = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic              instr_valid,
  input  logic              mem_ready,
  input  logic              branch_taken,
  input  logic              resume,
  output logic              ir_load,
  output logic              pc_en,
  output logic              jump,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic [FUNC_W-1:0] alu_op,
  output logic              halted,
  output logic              mem_err,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [FUNC_W-1:0] FUNC_HALT = {FUNC_W{HALT_FUNC_BIT}};
  localparam int                LS_BIT    = FUNC_W - 1 - LS_BIT_FROM_MSB;
  localparam int                LOW_W     = INSTR_W - TYPE_W - FUNC_W;

  state_e              state;
  logic [TYPE_W-1:0]   type_q;
  logic [FUNC_W-1:0]   func_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                reg_write_q;
  logic                halted_q;
  logic                pc_en_q;
  logic                mem_err_q;

  logic                is_m;
  logic                is_b;
  logic                is_s;
  logic                is_store;
  logic                is_halt;
  logic                in_mem;
  logic                tmo_clr;
  logic                mem_expired;
  logic                mem_pc_en;

  // Bits below the function field carry operands, not control.
  if (LOW_W > 0) begin : g_low
    logic unused_low;
    assign unused_low = ^instr[LOW_W-1:0];
  end

  assign is_m     = (type_q == TYPE_W'(M));
  assign is_b     = (type_q == TYPE_W'(B));
  assign is_s     = (type_q == TYPE_W'(S));
  assign is_store = func_q[LS_BIT];
  assign is_halt  = (func_q == FUNC_HALT);
  assign in_mem   = (state == MEM);
  assign tmo_clr  = (state == EXEC);

  mem_timeout_cnt #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_mem_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (in_mem),
    .expired (mem_expired)
  );

  // Sequencer. The registered strobes are loaded with the values that belong
  // to the state being entered, so they behave as Moore outputs of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      type_q      <= '0;
      func_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      halted_q    <= 1'b0;
      pc_en_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      halted_q    <= 1'b0;
      pc_en_q     <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            type_q <= instr[INSTR_W-1 -: TYPE_W];
            func_q <= instr[INSTR_W-TYPE_W-1 -: FUNC_W];
            state  <= DECODE;
          end
        end
        DECODE: begin
          state   <= EXEC;
          pc_en_q <= is_b;
        end
        EXEC: begin
          if (is_m) begin
            state       <= MEM;
            mem_read_q  <= !is_store;
            mem_write_q <= is_store;
          end else if (is_b) begin
            state <= FETCH;
          end else if (is_s && is_halt) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            state       <= WB;
            reg_write_q <= 1'b1;
            pc_en_q     <= 1'b1;
          end
        end
        MEM: begin
          // mem_ready takes priority over a simultaneous timeout.
          if (mem_ready) begin
            if (is_store) begin
              state <= FETCH;
            end else begin
              state       <= WB;
              reg_write_q <= 1'b1;
              pc_en_q     <= 1'b1;
            end
          end else if (mem_expired) begin
            state     <= FETCH;
            mem_err_q <= 1'b1;
          end else begin
            mem_read_q  <= !is_store;
            mem_write_q <= is_store;
          end
        end
        WB: begin
          state <= FETCH;
        end
        HALT: begin
          if (resume) begin
            state <= FETCH;
          end else begin
            halted_q <= 1'b1;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // MEM exits depend on mem_ready / expiry in the same cycle, so their PC
  // update is combinational; likewise the resume-driven one.
  assign mem_pc_en = in_mem && ((is_store && mem_ready) || (mem_expired && !mem_ready));

  assign ir_load   = rst_n && (state == FETCH) && instr_valid;
  assign jump      = (state == EXEC) && is_b && branch_taken;
  assign pc_en     = pc_en_q || mem_pc_en || ((state == HALT) && resume);
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign reg_write = reg_write_q;
  assign halted    = halted_q;
  assign alu_op    = func_q;
  assign mem_err   = mem_err_q;

`ifdef CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retired_q;

  assign retire = ((state == EXEC) && is_b)
               || ((state == EXEC) && is_s && is_halt)
               || (in_mem && is_store && mem_ready)
               || (state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if (state != HALT) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario pushes the expected
// per-cycle output vector {ir_load,pc_en,jump,mem_read,mem_write,reg_write,
// halted,alu_op} into a queue, then drives the cycles and pops/compares.
// Counter expectations come from a small model (zero when CTRL_PERF_EN is
// not defined).
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

`ifdef CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  instr = 9'h000;
  logic        instr_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        resume = 1'b0;
  logic        ir_load, pc_en, jump, mem_read, mem_write, reg_write, halted, mem_err;
  logic [2:0]  alu_op;
  logic [15:0] cycle_cnt, retired_cnt;

  logic [9:0]  obs;
  logic [9:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_cyc;
  logic [15:0] m_ret = 16'd0;
  logic        m_halt = 1'b0;
  logic [2:0]  m_op = 3'd0;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .resume       (resume),
    .ir_load      (ir_load),
    .pc_en        (pc_en),
    .jump         (jump),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .alu_op       (alu_op),
    .halted       (halted),
    .mem_err      (mem_err),
    .cycle_cnt    (cycle_cnt),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {ir_load, pc_en, jump, mem_read, mem_write, reg_write, halted, alu_op};

  // Reference cycle counter: counts every cycle whose expected halted is 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cyc <= 16'd0;
    else if (!m_halt) m_cyc <= m_cyc + 16'd1;
  end

  task automatic test_reset();
    logic [15:0] z;
    z = 16'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (obs !== 10'd0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 10'd0); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL reset_mem_err got=%b want=0", mem_err); end
    total++; if (cycle_cnt !== z) begin bad++; $display("FAIL reset_cycle_cnt got=%0d want=0", cycle_cnt); end
    total++; if (retired_cnt !== z) begin bad++; $display("FAIL reset_retired_cnt got=%0d want=0", retired_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_r();
    logic [9:0]  e;
    logic [15:0] x;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd1});
    exp_q.push_back({7'b0000000, 3'd1});
    exp_q.push_back({7'b0100010, 3'd1});
    exp_q.push_back({7'b0000000, 3'd1});
    instr = 9'h010;
    for (int c = 0; c < 5; c++) begin
      instr_valid = (c == 0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL r_type c=%0d got=%b want=%b", c, obs, e); end
      m_halt = e[3];
      @(negedge clk);
    end
    m_op = 3'd1;
    m_ret++;
    x = PERF ? m_ret : 16'd0;
    total++; if (retired_cnt !== x) begin bad++; $display("FAIL r_retired got=%0d want=%0d", retired_cnt, x); end
    x = PERF ? m_cyc : 16'd0;
    total++; if (cycle_cnt !== x) begin bad++; $display("FAIL r_cycles got=%0d want=%0d", cycle_cnt, x); end
  endtask

  task automatic test_load();
    logic [9:0]  e;
    logic [15:0] x;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd0});
    exp_q.push_back({7'b0000000, 3'd0});
    exp_q.push_back({7'b0001000, 3'd0});
    exp_q.push_back({7'b0001000, 3'd0});
    exp_q.push_back({7'b0100010, 3'd0});
    exp_q.push_back({7'b0000000, 3'd0});
    instr = 9'h080;
    for (int c = 0; c < 7; c++) begin
      instr_valid = (c == 0);
      mem_ready = (c == 1) || (c == 4);  // the DECODE pulse must be ignored
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL load c=%0d got=%b want=%b", c, obs, e); end
      m_halt = e[3];
      @(negedge clk);
    end
    mem_ready = 1'b0;
    m_op = 3'd0;
    m_ret++;
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL load_mem_err got=%b want=0", mem_err); end
    x = PERF ? m_ret : 16'd0;
    total++; if (retired_cnt !== x) begin bad++; $display("FAIL load_retired got=%0d want=%0d", retired_cnt, x); end
  endtask

  task automatic test_load_ready_at_timeout();
    logic [9:0]  e;
    logic [15:0] x;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd0});
    exp_q.push_back({7'b0000000, 3'd0});
    for (int k = 0; k < 15; k++) exp_q.push_back({7'b0001000, 3'd0});
    exp_q.push_back({7'b0100010, 3'd0});
    exp_q.push_back({7'b0000000, 3'd0});
    instr = 9'h080;
    for (int c = 0; c < 20; c++) begin
      instr_valid = (c == 0);
      mem_ready = (c == 17);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL load_late c=%0d got=%b want=%b", c, obs, e); end
      m_halt = e[3];
      @(negedge clk);
    end
    mem_ready = 1'b0;
    m_op = 3'd0;
    m_ret++;
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL load_late_mem_err got=%b want=0", mem_err); end
    x = PERF ? m_ret : 16'd0;
    total++; if (retired_cnt !== x) begin bad++; $display("FAIL load_late_retired got=%0d want=%0d", retired_cnt, x); end
  endtask

  task automatic test_store_ready();
    logic [9:0]  e;
    logic [15:0] x;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd4});
    exp_q.push_back({7'b0000000, 3'd4});
    exp_q.push_back({7'b0100100, 3'd4});
    exp_q.push_back({7'b0000000, 3'd4});
    instr = 9'h0C0;
    for (int c = 0; c < 5; c++) begin
      instr_valid = (c == 0);
      mem_ready = (c == 3);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL store c=%0d got=%b want=%b", c, obs, e); end
      m_halt = e[3];
      @(negedge clk);
    end
    mem_ready = 1'b0;
    m_op = 3'd4;
    m_ret++;
    x = PERF ? m_ret : 16'd0;
    total++; if (retired_cnt !== x) begin bad++; $display("FAIL store_retired got=%0d want=%0d", retired_cnt, x); end
  endtask

  task automatic test_branch(input logic bt);
    logic [9:0]  e;
    logic [15:0] x;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd0});
    exp_q.push_back({1'b0, 1'b1, bt, 4'b0000, 3'd0});
    exp_q.push_back({7'b0000000, 3'd0});
    instr = 9'h100;
    for (int c = 0; c < 4; c++) begin
      instr_valid = (c == 0);
      branch_taken = (c == 2) ? bt : 1'b1;  // high outside EXEC must not jump
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL branch%0d c=%0d got=%b want=%b", bt, c, obs, e); end
      m_halt = e[3];
      @(negedge clk);
    end
    branch_taken = 1'b0;
    m_op = 3'd0;
    m_ret++;
    x = PERF ? m_ret : 16'd0;
    total++; if (retired_cnt !== x) begin bad++; $display("FAIL branch%0d_retired got=%0d want=%0d", bt, retired_cnt, x); end
  endtask

  task automatic test_halt();
    logic [9:0]  e;
    logic [15:0] x;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd7});
    exp_q.push_back({7'b0000000, 3'd7});
    for (int k = 0; k < 10; k++) exp_q.push_back({7'b0000001, 3'd7});
    exp_q.push_back({7'b0100001, 3'd7});
    exp_q.push_back({7'b0000000, 3'd7});
    instr = 9'h1F0;
    for (int c = 0; c < 15; c++) begin
      instr_valid = (c == 0) || (c >= 3 && c <= 12);  // ignored while halted
      resume = (c == 1) || (c == 13);                 // DECODE pulse ignored
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL halt c=%0d got=%b want=%b", c, obs, e); end
      if (c == 12) begin
        x = PERF ? m_cyc : 16'd0;
        total++;
        if (cycle_cnt !== x) begin bad++; $display("FAIL halt_cycles_frozen got=%0d want=%0d", cycle_cnt, x); end
      end
      m_halt = e[3];
      @(negedge clk);
    end
    instr_valid = 1'b0;
    resume = 1'b0;
    m_halt = 1'b0;
    m_op = 3'd7;
    m_ret++;
    x = PERF ? m_ret : 16'd0;
    total++; if (retired_cnt !== x) begin bad++; $display("FAIL halt_retired got=%0d want=%0d", retired_cnt, x); end
    x = PERF ? m_cyc : 16'd0;
    total++; if (cycle_cnt !== x) begin bad++; $display("FAIL halt_cycles got=%0d want=%0d", cycle_cnt, x); end
  endtask

  task automatic test_store_timeout();
    logic [9:0]  e;
    logic [15:0] x;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd4});
    exp_q.push_back({7'b0000000, 3'd4});
    for (int k = 0; k < 14; k++) exp_q.push_back({7'b0000100, 3'd4});
    exp_q.push_back({7'b0100100, 3'd4});
    exp_q.push_back({7'b0000000, 3'd4});
    instr = 9'h0C0;
    mem_ready = 1'b0;
    for (int c = 0; c < 19; c++) begin
      instr_valid = (c == 0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL store_timeout c=%0d got=%b want=%b", c, obs, e); end
      m_halt = e[3];
      @(negedge clk);
    end
    m_op = 3'd4;
    total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL store_timeout_mem_err got=%b want=1", mem_err); end
    x = PERF ? m_ret : 16'd0;
    total++; if (retired_cnt !== x) begin bad++; $display("FAIL store_timeout_retired got=%0d want=%0d", retired_cnt, x); end
  endtask

  task automatic test_reset_mid_load();
    logic [9:0] e;
    exp_q.push_back({7'b1000000, m_op});
    exp_q.push_back({7'b0000000, 3'd0});
    exp_q.push_back({7'b0000000, 3'd0});
    exp_q.push_back({7'b0001000, 3'd0});
    instr = 9'h080;
    for (int c = 0; c < 4; c++) begin
      instr_valid = (c == 0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rst_mid c=%0d got=%b want=%b", c, obs, e); end
      m_halt = e[3];
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    total++; if (obs !== 10'd0) begin bad++; $display("FAIL rst_mid_outputs got=%b want=%b", obs, 10'd0); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rst_mid_mem_err got=%b want=0", mem_err); end
    total++; if (cycle_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_cycles got=%0d want=0", cycle_cnt); end
    total++; if (retired_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_retired got=%0d want=0", retired_cnt); end
    m_ret = 16'd0;
    m_op = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_r();
    test_load();
    test_load_ready_at_timeout();
    test_store_ready();
    test_branch(1'b1);
    test_branch(1'b0);
    test_halt();
    test_store_timeout();
    test_reset_mid_load();
    test_r();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
